calc_arbiter: RTL and testbench

Shared-access controller for the 4-bit calculator datapath (add/sub/mul/div, 8-bit result). It lets two requesters share one datapath instance through valid/ready request ports. It arbitrates round-robin (or fixed priority), registers operands, and holds the datapath for a configurable number of cycles. It returns the result on a single valid/ready response port tagged with the requester ID and a divide-by-zero flag.

---
 rtl/calc_arbiter.sv | 132 +++++++++++++
 tb/tb_calc_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/calc_arbiter.sv
// calc_arbiter
//   Lets two requesters share one 4-bit add/sub/mul/div datapath (8-bit result).
//   An idle arbiter grants one valid requester (round-robin or fixed priority)
//   and registers its operands. It holds the datapath for OP_LATENCY cycles,
//   then presents a registered, tagged response until the consumer takes it.
//
// Parameters
//   OP_LATENCY  cycles spent in EXEC before the result is captured (1..15)
//   FIXED_PRIO  0: round-robin on ties, 1: requester 0 always wins ties
//
// Ports
//   clk, rst_n                          clock, async active-low reset
//   reqN_valid/ready, reqN_op/a/b       command ports (N = 0, 1)
//   rsp_valid/ready                     response handshake
//   rsp_id, rsp_result, rsp_dz          issuing requester, result, div-by-zero
//   busy                                high whenever not IDLE (registered)
module calc_arbiter #(
    parameter int OP_LATENCY = 1,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [1:0] req0_op,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [1:0] req1_op,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [7:0] rsp_result,
    output logic       rsp_dz,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [3:0] LAT = 4'(OP_LATENCY);

    state_t     state;
    logic [3:0] cnt;
    logic       last_grant;   // 1 = requester 1 was granted last
    logic       id_q;
    logic [1:0] op_q;
    logic [3:0] a_q, b_q;

    logic       grant0;
    logic       accept;
    logic [7:0] dp_result;
    logic       dp_dz;

    // Requester 0 wins when alone, or on a tie when it is its turn / has priority.
    assign grant0     = req0_valid && (!req1_valid || FIXED_PRIO || last_grant);
    assign req0_ready = (state == IDLE) && grant0;
    assign req1_ready = (state == IDLE) && !grant0 && req1_valid;
    assign accept     = req0_ready || req1_ready;

    // Datapath on the captured operands, zero-extended, results mod 256.
    always_comb begin
        logic [7:0] a8, b8;
        a8        = {4'b0, a_q};
        b8        = {4'b0, b_q};
        dp_result = 8'h00;
        dp_dz     = 1'b0;
        case (op_q)
            2'b00: dp_result = a8 + b8;
            2'b01: dp_result = a8 - b8;
            2'b10: dp_result = a8 * b8;
            default: begin
                if (b_q == 4'd0) dp_dz     = 1'b1;
                else             dp_result = a8 / b8;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            last_grant <= 1'b1;
            id_q       <= 1'b0;
            op_q       <= 2'b00;
            a_q        <= 4'd0;
            b_q        <= 4'd0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= 8'h00;
            rsp_dz     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        id_q       <= !grant0;
                        last_grant <= !grant0;
                        op_q       <= grant0 ? req0_op : req1_op;
                        a_q        <= grant0 ? req0_a  : req1_a;
                        b_q        <= grant0 ? req0_b  : req1_b;
                        cnt        <= LAT;
                        busy       <= 1'b1;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        rsp_result <= dp_result;
                        rsp_dz     <= dp_dz;
                        rsp_id     <= id_q;
                        rsp_valid  <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    // Always return through IDLE; no same-edge re-accept.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_arbiter.sv
// Self-checking bench for calc_arbiter. Two instances run side by side:
// index 0 is round-robin with OP_LATENCY=1, index 1 is fixed priority with
// OP_LATENCY=4. Each transaction is checked against a transaction-level model
// (arithmetic rules, arbitration rule, latency, stability, idle gap).
module tb_calc_arbiter;

    localparam int LAT0 = 1;
    localparam int LAT1 = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       v0 [2], v1 [2], rrdy [2];
    logic [1:0] op0 [2], op1 [2];
    logic [3:0] a0 [2], b0 [2], a1 [2], b1 [2];
    logic       rd0 [2], rd1 [2], rv [2], rid [2], rdz [2], bsy [2];
    logic [7:0] rres [2];

    int n_vec = 0;
    int n_err = 0;
    bit last [2];   // model: 1 = requester 1 granted last

    calc_arbiter #(.OP_LATENCY(LAT0), .FIXED_PRIO(1'b0)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(v0[0]), .req0_ready(rd0[0]), .req0_op(op0[0]), .req0_a(a0[0]), .req0_b(b0[0]),
        .req1_valid(v1[0]), .req1_ready(rd1[0]), .req1_op(op1[0]), .req1_a(a1[0]), .req1_b(b1[0]),
        .rsp_valid(rv[0]), .rsp_ready(rrdy[0]), .rsp_id(rid[0]), .rsp_result(rres[0]),
        .rsp_dz(rdz[0]), .busy(bsy[0])
    );

    calc_arbiter #(.OP_LATENCY(LAT1), .FIXED_PRIO(1'b1)) u_fp (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(v0[1]), .req0_ready(rd0[1]), .req0_op(op0[1]), .req0_a(a0[1]), .req0_b(b0[1]),
        .req1_valid(v1[1]), .req1_ready(rd1[1]), .req1_op(op1[1]), .req1_a(a1[1]), .req1_b(b1[1]),
        .rsp_valid(rv[1]), .rsp_ready(rrdy[1]), .rsp_id(rid[1]), .rsp_result(rres[1]),
        .rsp_dz(rdz[1]), .busy(bsy[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int lat(input int d);
        return (d == 0) ? LAT0 : LAT1;
    endfunction

    // {dz, result} from the arithmetic rules.
    function automatic logic [8:0] ref_calc(input logic [1:0] op, input logic [3:0] a,
                                            input logic [3:0] b);
        int x, y;
        x = int'(a);
        y = int'(b);
        case (op)
            2'd0:    return 9'((x + y) % 256);
            2'd1:    return 9'((x - y + 256) % 256);
            2'd2:    return 9'((x * y) % 256);
            default: return (y == 0) ? 9'h100 : 9'(x / y);
        endcase
    endfunction

    task automatic chk_reset_vals();
        for (int d = 0; d < 2; d++) begin
            chk("rst_rsp_valid", rv[d], 0);
            chk("rst_rsp_id", rid[d], 0);
            chk("rst_rsp_result", rres[d], 0);
            chk("rst_rsp_dz", rdz[d], 0);
            chk("rst_busy", bsy[d], 0);
        end
    endtask

    // One full transaction on instance d with the given requester enables.
    task automatic do_txn(input int d, input bit e0, input bit e1,
                          input logic [1:0] o0, input logic [3:0] x0, input logic [3:0] y0,
                          input logic [1:0] o1, input logic [3:0] x1, input logic [3:0] y1,
                          input int stall);
        logic [8:0] exp;
        int w, n;
        @(negedge clk);
        v0[d] = e0; op0[d] = o0; a0[d] = x0; b0[d] = y0;
        v1[d] = e1; op1[d] = o1; a1[d] = x1; b1[d] = y1;
        #1;
        w = (e0 && (!e1 || d == 1 || last[d])) ? 0 : 1;
        chk("req0_ready", rd0[d], w == 0);
        chk("req1_ready", rd1[d], w == 1);
        if (!(rd0[d] || rd1[d])) begin
            v0[d] = 1'b0; v1[d] = 1'b0;
            return;
        end
        exp = (w == 0) ? ref_calc(o0, x0, y0) : ref_calc(o1, x1, y1);
        @(posedge clk);                 // accepting edge
        last[d] = (w == 1);
        @(negedge clk);
        if (w == 0) v0[d] = 1'b0; else v1[d] = 1'b0;   // loser keeps waiting
        #1;
        n = 0;
        while (!rv[d] && n < 40) begin
            chk("exec_busy", bsy[d], 1);
            chk("exec_ready", {rd0[d], rd1[d]}, 0);
            @(negedge clk); #1;
            n++;
        end
        // rsp_valid after OP_LATENCY edges beyond the accepting edge.
        chk("latency", n, lat(d));
        if (!rv[d]) begin
            v0[d] = 1'b0; v1[d] = 1'b0;
            return;
        end
        for (int s = 0; s <= stall; s++) begin
            if (s == stall) begin
                rrdy[d] = 1'b1;
                #1;
            end
            chk("rsp_valid", rv[d], 1);
            chk("rsp_id", rid[d], w);
            chk("rsp_result", rres[d], exp[7:0]);
            chk("rsp_dz", rdz[d], exp[8]);
            chk("resp_ready_low", {rd0[d], rd1[d]}, 0);
            chk("resp_busy", bsy[d], 1);
            if (s != stall) begin
                @(negedge clk); #1;
            end
        end
        @(negedge clk);                 // handshake edge has passed
        rrdy[d] = 1'b0;
        #1;
        chk("post_rsp_valid", rv[d], 0);
        chk("post_busy", bsy[d], 0);
        if (e0 && e1) begin
            // Waiting requester is re-arbitrated in this idle cycle.
            chk("requeue_ready", {rd0[d], rd1[d]}, (w == 0) ? 2'b01 : 2'b10);
        end
        v0[d] = 1'b0; v1[d] = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        last[0] = 1'b1; last[1] = 1'b1;
        for (int d = 0; d < 2; d++) begin
            v0[d] = 0; v1[d] = 0; rrdy[d] = 0;
            op0[d] = 0; op1[d] = 0; a0[d] = 0; b0[d] = 0; a1[d] = 0; b1[d] = 0;
        end
        #12;
        chk_reset_vals();
        @(negedge clk);
        rst_n = 1'b1;

        // Round-robin ties: ids 0,1,0,1.
        for (int i = 0; i < 4; i++)
            do_txn(0, 1, 1, 2'd0, 4'(i), 4'd1, 2'd2, 4'd3, 4'(i), 0);

        // Single command and arithmetic corners.
        do_txn(0, 1, 0, 2'd0, 4'd9,  4'd8,  2'd0, 4'd0, 4'd0, 0);   // 0x11
        do_txn(0, 1, 0, 2'd1, 4'd3,  4'd5,  2'd0, 4'd0, 4'd0, 0);   // 0xFE
        do_txn(0, 0, 1, 2'd0, 4'd0,  4'd0,  2'd2, 4'd15, 4'd15, 0); // 0xE1
        do_txn(0, 1, 0, 2'd3, 4'd13, 4'd4,  2'd0, 4'd0, 4'd0, 0);   // 0x03
        do_txn(0, 0, 1, 2'd0, 4'd0,  4'd0,  2'd3, 4'd0, 4'd9, 0);   // 0x00
        do_txn(0, 1, 0, 2'd3, 4'd7,  4'd0,  2'd0, 4'd0, 4'd0, 0);   // dz

        // Backpressure: 5 stalled cycles in RESP with both requesters waiting.
        do_txn(0, 1, 1, 2'd2, 4'd6, 4'd7, 2'd1, 4'd2, 4'd9, 5);

        // Fixed priority, OP_LATENCY=4: ids 0,0,0,0.
        for (int i = 0; i < 4; i++)
            do_txn(1, 1, 1, 2'd0, 4'd5, 4'(i), 2'd1, 4'd1, 4'd1, i % 2);

        // Randomized transactions on both instances.
        for (int i = 0; i < 40; i++) begin
            int d, en;
            d  = int'($urandom_range(0, 1));
            en = int'($urandom_range(1, 3));
            do_txn(d, en[0], en[1],
                   2'($urandom), 4'($urandom), 4'($urandom),
                   2'($urandom), 4'($urandom), 4'($urandom),
                   int'($urandom_range(0, 3)));
        end

        // Reset during EXEC: leave last grant on requester 0, then reset.
        @(negedge clk);
        v0[1] = 1'b1; op0[1] = 2'd0; a0[1] = 4'd1; b0[1] = 4'd2;
        #1;
        chk("rst_test_accept", rd0[1], 1);
        @(posedge clk);
        @(negedge clk);
        v0[1] = 1'b0;
        #1;
        chk("rst_test_busy", bsy[1], 1);
        rst_n = 1'b0;
        #1;
        chk_reset_vals();
        @(negedge clk);
        rst_n = 1'b1;
        last[0] = 1'b1; last[1] = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); #1;
            chk("no_rsp_after_reset", rv[1], 0);
        end
        // Next tie on the round-robin instance goes to requester 0.
        do_txn(0, 0, 1, 2'd0, 4'd1, 4'd1, 2'd0, 4'd2, 4'd2, 0);
        do_txn(0, 1, 1, 2'd0, 4'd4, 4'd4, 2'd0, 4'd8, 4'd8, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
